// File: rtl/reg_pair_sequencer_pkg.sv
// Shared constants for the 4004 register-pair access sequencer.
// Define TB4004_REGSEQ_INC_EN to make op 100 (INC4) a legal operation.
package tb4004_regseq_pkg;

  localparam int DATA_W = 4;
  localparam int ADDR_W = 4;

  localparam logic [2:0] OP_RD4  = 3'b000;
  localparam logic [2:0] OP_WR4  = 3'b001;
  localparam logic [2:0] OP_RDP  = 3'b010;
  localparam logic [2:0] OP_WRP  = 3'b011;
  localparam logic [2:0] OP_INC4 = 3'b100;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACC_HI = 2'd1;
  localparam logic [1:0] ST_ACC_LO = 2'd2;
  localparam logic [1:0] ST_RSP    = 2'd3;

  function automatic logic is_pair_op(input logic [2:0] op);
    return (op == OP_RDP) || (op == OP_WRP);
  endfunction

  // Ops above the legal ceiling complete with an error and never touch the register file.
  function automatic logic op_legal(input logic [2:0] op);
`ifdef TB4004_REGSEQ_INC_EN
    return op <= OP_INC4;
`else
    return op <= OP_WRP;
`endif
  endfunction

endpackage

// File: rtl/reg_pair_sequencer.sv
// Turns nibble / register-pair requests into one or two cycles on the 16x4 register file.
// Define TB4004_REGSEQ_INC_EN to enable the INC4 read-modify-write (ISZ support).
module reg_pair_sequencer
  import tb4004_regseq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_idx,
  input  logic [7:0]        req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [7:0]        rsp_data,
  output logic              rsp_err,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_din,
  input  logic [DATA_W-1:0] rf_dout
);

  logic [1:0]        state_r;
  logic [2:0]        op_r;
  logic [ADDR_W-1:0] idx_r;
  logic [7:0]        wdata_r;
  logic [7:0]        data_r;
  logic              err_r;

  // Request latch, FSM and response data capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      op_r    <= 3'd0;
      idx_r   <= 4'd0;
      wdata_r <= 8'h00;
      data_r  <= 8'h00;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            op_r    <= req_op;
            idx_r   <= req_idx;
            wdata_r <= req_wdata;
            if (!op_legal(req_op)) begin
              state_r <= ST_RSP;
              err_r   <= 1'b1;
              data_r  <= 8'h00;
            end else begin
              state_r <= ST_ACC_HI;
              err_r   <= 1'b0;
              // Writes echo their value, so it is parked in the response register up front.
              case (req_op)
                OP_WR4:  data_r <= {4'h0, req_wdata[3:0]};
                OP_WRP:  data_r <= req_wdata;
                default: data_r <= 8'h00;
              endcase
            end
          end
        end
        ST_ACC_HI: begin
          case (op_r)
            OP_RD4:  data_r      <= {4'h0, rf_dout};
            OP_RDP:  data_r[7:4] <= rf_dout;
`ifdef TB4004_REGSEQ_INC_EN
            OP_INC4: data_r      <= {3'b000, (rf_dout == 4'hF), rf_dout + 4'h1};
`endif
            default: data_r      <= data_r;
          endcase
          state_r <= is_pair_op(op_r) ? ST_ACC_LO : ST_RSP;
        end
        ST_ACC_LO: begin
          if (op_r == OP_RDP) begin
            data_r[3:0] <= rf_dout;
          end
          state_r <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_r == ST_IDLE);
  assign rsp_valid = (state_r == ST_RSP);
  assign rsp_data  = data_r;
  assign rsp_err   = err_r;

  // Register-file port drive; idle outside the two access states.
  always_comb begin
    rf_we   = 1'b0;
    rf_addr = 4'd0;
    rf_din  = 4'd0;
    case (state_r)
      ST_ACC_HI: begin
        if (is_pair_op(op_r)) begin
          rf_addr = {idx_r[3:1], 1'b0};
        end else begin
          rf_addr = idx_r;
        end
        case (op_r)
          OP_WR4: begin
            rf_we  = 1'b1;
            rf_din = wdata_r[3:0];
          end
          OP_WRP: begin
            rf_we  = 1'b1;
            rf_din = wdata_r[7:4];
          end
`ifdef TB4004_REGSEQ_INC_EN
          OP_INC4: begin
            rf_we  = 1'b1;
            rf_din = rf_dout + 4'h1;
          end
`endif
          default: begin
            rf_we  = 1'b0;
            rf_din = 4'd0;
          end
        endcase
      end
      ST_ACC_LO: begin
        rf_addr = {idx_r[3:1], 1'b1};
        if (op_r == OP_WRP) begin
          rf_we  = 1'b1;
          rf_din = wdata_r[3:0];
        end else begin
          rf_we  = 1'b0;
          rf_din = 4'd0;
        end
      end
      default: begin
        rf_we   = 1'b0;
        rf_addr = 4'd0;
        rf_din  = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_pair_sequencer.sv
// Self-checking bench for reg_pair_sequencer with a behavioural 16x4 register file.
// Compile with TB4004_REGSEQ_INC_EN to match an RTL build that has INC4 enabled.
module tb_reg_pair_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [2:0] req_op = 3'd0;
  logic [3:0] req_idx = 4'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       rf_we;
  logic [3:0] rf_addr;
  logic [3:0] rf_din;
  logic [3:0] rf_dout;

  int n_checks = 0;
  int n_errors = 0;
  int we_cnt = 0;

  logic [3:0] rf_mem [16];
  logic [3:0] model_regs [16];

  typedef struct packed {
    logic       req_ready;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       rf_we;
    logic [3:0] rf_addr;
    logic [3:0] rf_din;
  } exp_t;

  exp_t exp_q[$];

  reg_pair_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_idx(req_idx), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_din(rf_din), .rf_dout(rf_dout)
  );

  always #5 clk = ~clk;

  // Behavioural register file: combinational read, write on the rising edge.
  assign rf_dout = rf_mem[rf_addr];
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_addr] <= rf_din;
  end

  always @(negedge clk) begin
    if (rst_n && rf_we) we_cnt++;
  end

  function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic legal(input logic [2:0] op);
`ifdef TB4004_REGSEQ_INC_EN
    return op <= 3'd4;
`else
    return op <= 3'd3;
`endif
  endfunction

  function automatic int exp_lat(input logic [2:0] op);
    if (!legal(op)) return 1;
    if (op == 3'd2 || op == 3'd3) return 3;
    return 2;
  endfunction

  function automatic exp_t acc(input logic [3:0] a, input logic w, input logic [3:0] d);
    exp_t e;
    e = '{req_ready: 1'b0, rsp_valid: 1'b0, rsp_data: 8'h00, rsp_err: 1'b0,
          rf_we: w, rf_addr: a, rf_din: d};
    return e;
  endfunction

  function automatic exp_t rsp(input logic [7:0] d, input logic err);
    exp_t e;
    e = '{req_ready: 1'b0, rsp_valid: 1'b1, rsp_data: d, rsp_err: err,
          rf_we: 1'b0, rf_addr: 4'd0, rf_din: 4'd0};
    return e;
  endfunction

  // Expected cycle-by-cycle schedule of one request, from the op's access list.
  function automatic void build_schedule(input logic [2:0] op, input logic [3:0] idx,
                                         input logic [7:0] wd);
    logic [3:0] ev;
    logic [3:0] od;
    logic [3:0] nv;
    ev = {idx[3:1], 1'b0};
    od = {idx[3:1], 1'b1};
    nv = model_regs[idx] + 4'h1;
    if (!legal(op)) begin
      exp_q.push_back(rsp(8'h00, 1'b1));
    end else begin
      case (op)
        3'd0: begin
          exp_q.push_back(acc(idx, 1'b0, 4'h0));
          exp_q.push_back(rsp({4'h0, model_regs[idx]}, 1'b0));
        end
        3'd1: begin
          exp_q.push_back(acc(idx, 1'b1, wd[3:0]));
          exp_q.push_back(rsp({4'h0, wd[3:0]}, 1'b0));
        end
        3'd2: begin
          exp_q.push_back(acc(ev, 1'b0, 4'h0));
          exp_q.push_back(acc(od, 1'b0, 4'h0));
          exp_q.push_back(rsp({model_regs[ev], model_regs[od]}, 1'b0));
        end
        3'd3: begin
          exp_q.push_back(acc(ev, 1'b1, wd[7:4]));
          exp_q.push_back(acc(od, 1'b1, wd[3:0]));
          exp_q.push_back(rsp(wd, 1'b0));
        end
        default: begin
          exp_q.push_back(acc(idx, 1'b1, nv));
          exp_q.push_back(rsp({3'b000, (nv == 4'h0), nv}, 1'b0));
        end
      endcase
    end
  endfunction

  // Reference model advance: consume one scheduled cycle per edge, accept only from idle.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      if (!(exp_q[0].rsp_valid && !rsp_ready)) begin
        if (exp_q[0].rf_we) model_regs[exp_q[0].rf_addr] <= exp_q[0].rf_din;
        void'(exp_q.pop_front());
      end
    end else if (req_valid) begin
      build_schedule(req_op, req_idx, req_wdata);
    end
  end

  // Per-cycle comparison of DUT outputs against the model schedule.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (exp_q.size() > 0) e = exp_q[0];
      else e = '{req_ready: 1'b1, rsp_valid: 1'b0, rsp_data: 8'h00, rsp_err: 1'b0,
                 rf_we: 1'b0, rf_addr: 4'd0, rf_din: 4'd0};
      chk("req_ready", {7'd0, req_ready}, {7'd0, e.req_ready});
      chk("rsp_valid", {7'd0, rsp_valid}, {7'd0, e.rsp_valid});
      chk("rf_we", {7'd0, rf_we}, {7'd0, e.rf_we});
      chk("rf_addr", {4'd0, rf_addr}, {4'd0, e.rf_addr});
      chk("rf_din", {4'd0, rf_din}, {4'd0, e.rf_din});
      if (e.rsp_valid) begin
        chk("rsp_data", rsp_data, e.rsp_data);
        chk("rsp_err", {7'd0, rsp_err}, {7'd0, e.rsp_err});
      end
    end
  end

  // One request/response handshake; called at posedge+1, returns at posedge+1 after completion.
  task automatic do_op(input logic [2:0] op, input logic [3:0] idx, input logic [7:0] wd,
                       input int hold, output logic [7:0] rdata, output logic rerr,
                       output int lat);
    int waited;
    waited = 0;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    chk("req_ready_wait", {7'd0, req_ready}, 8'h01);
    req_valid = 1'b1;
    req_op    = op;
    req_idx   = idx;
    req_wdata = wd;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    chk("rsp_timeout", {7'd0, rsp_valid}, 8'h01);
    chk("latency", lat[7:0], exp_lat(op));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    rdata = rsp_data;
    rerr  = rsp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] rd;
    logic       er;
    int         lat;
    int         w0;

    for (int i = 0; i < 16; i++) begin
      rf_mem[i]     = 4'(i);
      model_regs[i] = 4'(i);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {7'd0, req_ready}, 8'h01);
    chk("rst_rsp_valid", {7'd0, rsp_valid}, 8'h00);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_rsp_err", {7'd0, rsp_err}, 8'h00);
    chk("rst_rf_we", {7'd0, rf_we}, 8'h00);
    chk("rst_rf_addr", {4'd0, rf_addr}, 8'h00);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pair write then pair read on pair 3.
    do_op(3'd3, 4'd6, 8'hA5, 0, rd, er, lat);
    chk("wrp_lat", lat[7:0], 8'd3);
    chk("wrp_r6", {4'd0, rf_mem[6]}, 8'h0A);
    chk("wrp_r7", {4'd0, rf_mem[7]}, 8'h05);
    do_op(3'd2, 4'd7, 8'h00, 0, rd, er, lat);
    chk("rdp_data", rd, 8'hA5);
    chk("rdp_lat", lat[7:0], 8'd3);

    // Nibble write/read on the last register.
    w0 = we_cnt;
    do_op(3'd1, 4'd15, 8'h0C, 0, rd, er, lat);
    chk("wr4_we_pulses", 8'(we_cnt - w0), 8'd1);
    chk("wr4_lat", lat[7:0], 8'd2);
    do_op(3'd0, 4'd15, 8'h00, 0, rd, er, lat);
    chk("rd4_data", rd, 8'h0C);

    // Pair read held off by the consumer for 5 cycles.
    w0 = we_cnt;
    do_op(3'd2, 4'd6, 8'h00, 5, rd, er, lat);
    chk("stall_data", rd, 8'hA5);
    chk("stall_we_pulses", 8'(we_cnt - w0), 8'd0);
    chk("stall_idle", {7'd0, req_ready}, 8'h01);

    // Illegal op.
    w0 = we_cnt;
    do_op(3'd6, 4'd3, 8'hFF, 0, rd, er, lat);
    chk("ill_err", {7'd0, er}, 8'h01);
    chk("ill_data", rd, 8'h00);
    chk("ill_lat", lat[7:0], 8'd1);
    chk("ill_we_pulses", 8'(we_cnt - w0), 8'd0);

    // INC4 on R2 = F.
    do_op(3'd1, 4'd2, 8'h0F, 0, rd, er, lat);
    do_op(3'd4, 4'd2, 8'h00, 0, rd, er, lat);
`ifdef TB4004_REGSEQ_INC_EN
    chk("inc_data", rd, 8'h10);
    chk("inc_err", {7'd0, er}, 8'h00);
    chk("inc_r2", {4'd0, rf_mem[2]}, 8'h00);
`else
    chk("inc_err", {7'd0, er}, 8'h01);
    chk("inc_r2", {4'd0, rf_mem[2]}, 8'h0F);
`endif

    // Reset during the odd-register cycle of a pair write.
    do_op(3'd1, 4'd1, 8'h07, 0, rd, er, lat);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 3'd3; req_idx = 4'd0; req_wdata = 8'h3C;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("abort_req_ready", {7'd0, req_ready}, 8'h01);
    chk("abort_rsp_valid", {7'd0, rsp_valid}, 8'h00);
    chk("abort_rsp_data", rsp_data, 8'h00);
    chk("abort_rf_we", {7'd0, rf_we}, 8'h00);
    chk("abort_rf_addr", {4'd0, rf_addr}, 8'h00);
    chk("abort_rf_din", {4'd0, rf_din}, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_r0", {4'd0, rf_mem[0]}, 8'h03);
    chk("abort_r1", {4'd0, rf_mem[1]}, 8'h07);
    @(posedge clk); #1;

    // Randomized traffic against the model.
    for (int n = 0; n < 150; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      do_op(op, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, rd, er, lat);
    end

    repeat (2) @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      chk("final_regs", {4'd0, rf_mem[i]}, {4'd0, model_regs[i]});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
